// File: rtl/gpi_debounce_pkg.sv
// Shared defaults and width helpers for the GPI debounce filter.
package gpi_debounce_pkg;

   localparam int unsigned TickDivDefault     = 100000;
   localparam int unsigned StableCountDefault = 4;

   // Bits needed to hold values 0..n-1, never less than 1.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/gpi_debounce_bit.sv
// One debounced GPI bit: stability counter, level register and edge pulses.
module gpi_debounce_bit
   import gpi_debounce_pkg::*;
#(
   parameter int unsigned StableCount = StableCountDefault,
   parameter logic        ResetVal    = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic enable_i,
   input  logic tick_i,
   input  logic sync_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int unsigned CW = cnt_width(StableCount + 1);
   localparam logic [CW-1:0] CntLast = CW'(StableCount - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         level_o <= ResetVal;
         rise_o  <= 1'b0;
         fall_o  <= 1'b0;
      end else begin
         rise_o <= 1'b0;
         fall_o <= 1'b0;
         if (!enable_i) begin
            cnt_q <= '0;
         end else if (tick_i) begin
            if (sync_i == level_o) begin
               cnt_q <= '0;
            end else if (cnt_q == CntLast) begin
               // Pulse is registered alongside the new level so both appear together.
               cnt_q   <= '0;
               level_o <= ~level_o;
               rise_o  <= ~level_o;
               fall_o  <= level_o;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/gpi_debounce.sv
// GPI input conditioner: 2-flop synchroniser, shared tick prescaler, per-bit debounce.
module gpi_debounce
   import gpi_debounce_pkg::*;
#(
   parameter int unsigned       Width       = 8,
   parameter int unsigned       TickDiv     = TickDivDefault,
   parameter int unsigned       StableCount = StableCountDefault,
   parameter logic [Width-1:0]  ResetVal    = '0
) (
   input  logic             clk_sys_i,
   input  logic             rst_sys_ni,
   input  logic             enable_i,
   input  logic [Width-1:0] gp_raw_i,
   output logic [Width-1:0] gp_o,
   output logic [Width-1:0] rise_o,
   output logic [Width-1:0] fall_o,
   output logic             tick_o
);

   localparam int unsigned PW = cnt_width(TickDiv);
   localparam logic [PW-1:0] PresLast = PW'(TickDiv - 1);

   logic [Width-1:0] sync1_q, sync_q;
   logic [PW-1:0]    presc_q;

   always_ff @(posedge clk_sys_i) begin
      if (!rst_sys_ni) begin
         sync1_q <= ResetVal;
         sync_q  <= ResetVal;
      end else begin
         sync1_q <= gp_raw_i;
         sync_q  <= sync1_q;
      end
   end

   always_ff @(posedge clk_sys_i) begin
      if (!rst_sys_ni || !enable_i) begin
         presc_q <= '0;
      end else if (presc_q == PresLast) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_q + 1'b1;
      end
   end

   assign tick_o = enable_i && (presc_q == PresLast);

   for (genvar i = 0; i < Width; i++) begin : g_bit
      gpi_debounce_bit #(
         .StableCount (StableCount),
         .ResetVal    (ResetVal[i])
      ) u_bit (
         .clk_i    (clk_sys_i),
         .rst_ni   (rst_sys_ni),
         .enable_i (enable_i),
         .tick_i   (tick_o),
         .sync_i   (sync_q[i]),
         .level_o  (gp_o[i]),
         .rise_o   (rise_o[i]),
         .fall_o   (fall_o[i])
      );
   end

endmodule

// File: tb/tb_gpi_debounce.sv
// Directed bench for gpi_debounce with a cycle-level behavioural reference.
module tb_gpi_debounce;

   localparam int W  = 8;
   localparam int TD = 4;
   localparam int SC = 3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en;
   logic [W-1:0] raw;
   logic [W-1:0] gp_o, rise_o, fall_o;
   logic         tick_o;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   always #5 clk = ~clk;

   gpi_debounce #(
      .Width       (W),
      .TickDiv     (TD),
      .StableCount (SC),
      .ResetVal    (8'h00)
   ) dut (
      .clk_sys_i  (clk),
      .rst_sys_ni (rst_n),
      .enable_i   (en),
      .gp_raw_i   (raw),
      .gp_o       (gp_o),
      .rise_o     (rise_o),
      .fall_o     (fall_o),
      .tick_o     (tick_o)
   );

   // Reference: raw delayed two cycles, tick every TD enabled cycles,
   // a level is accepted after SC consecutive disagreeing ticks.
   logic [W-1:0] m_d1, m_d2, m_gp, m_rise, m_fall;
   int           m_phase;
   int           m_run [W];

   always @(posedge clk) begin
      bit tk;
      if (!rst_n) begin
         m_d1 = '0; m_d2 = '0; m_gp = '0; m_rise = '0; m_fall = '0; m_phase = 0;
         for (int i = 0; i < W; i++) m_run[i] = 0;
      end else begin
         tk = en && (m_phase == TD - 1);
         m_rise = '0; m_fall = '0;
         for (int i = 0; i < W; i++) begin
            if (!en) m_run[i] = 0;
            else if (tk) begin
               if (m_d2[i] != m_gp[i]) begin
                  m_run[i]++;
                  if (m_run[i] == SC) begin
                     m_run[i] = 0;
                     if (m_gp[i]) m_fall[i] = 1'b1; else m_rise[i] = 1'b1;
                     m_gp[i] = ~m_gp[i];
                  end
               end else m_run[i] = 0;
            end
         end
         m_phase = en ? (m_phase + 1) % TD : 0;
         m_d2 = m_d1;
         m_d1 = raw;
      end
   end

   int rise_cnt [W];
   int fall_cnt [W];
   int tick_cnt  = 0;
   int both_rise = 0;

   always @(negedge clk) begin
      logic m_tick;
      if (chk_en) begin
         m_tick = en && (m_phase == TD - 1);
         checks++;
         if ({gp_o, rise_o, fall_o, tick_o} !== {m_gp, m_rise, m_fall, m_tick}) begin
            errors++;
            $display("FAIL cycle_model t=%0t gp/rise/fall/tick got %h/%h/%h/%b want %h/%h/%h/%b",
                     $time, gp_o, rise_o, fall_o, tick_o, m_gp, m_rise, m_fall, m_tick);
         end
         for (int i = 0; i < W; i++) begin
            rise_cnt[i] += int'(rise_o[i]);
            fall_cnt[i] += int'(fall_o[i]);
         end
         tick_cnt  += int'(tick_o);
         both_rise += int'(rise_o == 8'h42);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
   endtask

   // Count negedges until gp_o[b] equals v; -1 on timeout.
   task automatic latency(input int b, input logic v, output int k);
      k = -1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (gp_o[b] === v) begin
            k = c;
            break;
         end
      end
      step(1);
   endtask

   task automatic wait_run(input int b, input int n);
      int c;
      for (c = 0; c < 60 && m_run[b] != n; c++) step(1);
      check("wait_run_bound", int'(m_run[b] == n), 1);
   endtask

   initial begin
      int k, r0;
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int k, r;
      for (int i = 0; i < W; i++) begin rise_cnt[i] = 0; fall_cnt[i] = 0; end
      rst_n = 1'b0; en = 1'b1; raw = '0;
      step(3);
      chk_en = 1;

      // Reset release idle
      rst_n = 1'b1;
      tick_cnt = 0;
      step(100);
      check("idle_gp", int'(gp_o), 0);
      check("idle_rise", rise_cnt[0] + rise_cnt[7], 0);
      check("idle_ticks", tick_cnt, 25);

      // Clean press and release on bit 0
      raw = 8'h01;
      latency(0, 1'b1, k);
      check("press_latency_ok", int'(k >= 11 && k <= 14), 1);
      step(5);
      check("press_gp", int'(gp_o), 8'h01);
      check("press_rise_cnt", rise_cnt[0], 1);
      raw = 8'h00;
      step(20);
      check("release_gp", int'(gp_o), 0);
      check("release_fall_cnt", fall_cnt[0], 1);

      // Bounce on bit 3
      r = rise_cnt[3];
      raw = 8'h08; step(5);
      raw = 8'h00; step(3);
      raw = 8'h08; step(25);
      check("bounce_gp3", int'(gp_o[3]), 1);
      check("bounce_one_rise", rise_cnt[3] - r, 1);

      // Simultaneous rise on bits 1 and 6
      both_rise = 0;
      raw = 8'h4A;
      step(20);
      check("simul_rise_cycles", both_rise, 1);
      check("simul_gp", int'(gp_o), 8'h4A);

      // Enable dropped mid-qualification
      do_reset();
      raw = 8'h20;
      wait_run(5, 2);
      en = 1'b0;
      step(20);
      check("disabled_gp", int'(gp_o), 0);
      check("disabled_no_rise", rise_cnt[5], 0);
      en = 1'b1;
      latency(5, 1'b1, k);
      check("reenable_latency", k, 12);

      // Reset mid-qualification on bit 2
      do_reset();
      raw = 8'h04;
      wait_run(2, 2);
      r = rise_cnt[2];
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      check("midreset_gp", int'(gp_o), 0);
      latency(2, 1'b1, k);
      check("midreset_latency", k, 12);
      check("midreset_one_rise", rise_cnt[2] - r, 1);

      step(4);
      chk_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gpi_debounce.md
Name: gpi_debounce

Overview:
Board-level input conditioner that sits between the raw SW/BTN pins and the gp_i port of ibex_demo_system. It synchronises each asynchronous input and filters it with a shared sample-tick prescaler and a per-bit stability counter. It outputs a clean level, plus single-cycle rise and fall event pulses. Software then reads bounce-free GPI values, and the event pulses can later feed an interrupt source.

Parameters:
Width, 8, number of input bits (matches GpiWidth).
TickDiv, 100000, clk_sys_i cycles per sample tick (1 ms at 100 MHz); must be >= 2.
StableCount, 4, number of consecutive ticks a new level must hold before it is accepted; must be >= 1.
ResetVal, '0, Width-bit value loaded into the synchroniser and gp_o at reset.

Ports:
clk_sys_i  input  1  system clock
rst_sys_ni  input  1  synchronous, active-low reset
enable_i  input  1  filter enable; low freezes the outputs and clears the counters
gp_raw_i  input  Width  raw asynchronous pin levels
gp_o  output  Width  debounced levels
rise_o  output  Width  1-cycle pulse when a gp_o bit goes 0->1
fall_o  output  Width  1-cycle pulse when a gp_o bit goes 1->0
tick_o  output  1  1-cycle sample strobe, for observability

Behaviour:
- Clock and reset: one clock, clk_sys_i. Reset is synchronous and active-low on rst_sys_ni.
- Reset values: sync stages = ResetVal, gp_o = ResetVal, rise_o = fall_o = 0, tick_o = 0, prescaler = 0, all bit counters = 0.
- Because reset loads ResetVal everywhere, no edge pulse occurs at reset release.
- Synchroniser: 2-flop synchroniser per bit; sync_q is gp_raw_i delayed by 2 cycles.
- Prescaler:
  - Counts 0..TickDiv-1 and wraps to 0.
  - tick_o is combinational, high while prescaler == TickDiv-1 and enable_i = 1.
  - Counter width is $clog2(TickDiv).
- Per-bit counter cnt[i]:
  - Width is $clog2(StableCount+1); updated only on tick.
  - On tick with sync_q[i] == gp_o[i]: cnt[i] <= 0, no event.
  - On tick with mismatch and cnt[i] < StableCount-1: cnt[i] increments.
  - On tick with mismatch and cnt[i] == StableCount-1: gp_o[i] toggles at the next edge, cnt[i] <= 0, and rise_o[i]/fall_o[i] asserts for exactly that one cycle, aligned with the new gp_o value.
- Latency:
  - gp_o changes one cycle after the StableCount-th consecutive mismatching tick.
  - Worst case from a raw change is 2 + StableCount*TickDiv + 1 cycles.
- Glitch rejection: any tick that sees agreement resets progress. A glitch shorter than one tick period may or may not be sampled, but it is never accepted unless it holds for StableCount ticks.
- Independence: bits are independent, and multiple bits may fire events in the same cycle.
- enable_i low:
  - Prescaler held at 0, cnt cleared, gp_o holds, rise_o/fall_o = 0; the synchroniser keeps running.
  - When enable_i is re-asserted, a full StableCount ticks are needed before any change is accepted.
- Reset mid-filter (counter partially advanced): all state returns to reset values on the next edge, with no pulse.
- StableCount = 1: a single mismatching tick is accepted.
- Outputs are registered, except tick_o.

Decomposition:
- gpi_debounce_pkg holds:
  - default constants: TickDivDefault = 100000 and StableCountDefault = 4;
  - a function computing the counter widths.
- One sub-module, gpi_debounce_bit, holds the per-bit counter, the level register and the edge-pulse logic, and takes tick and sync_q as inputs. It is instantiated Width times in a generate loop.
- The shared prescaler and synchroniser stay in the top module.

Test Plan:
All scenarios use TickDiv=4, StableCount=3, Width=8, ResetVal=0.
- Reset release with gp_raw_i=0x00: gp_o=0x00, no rise/fall pulses for 100 cycles, tick_o high every 4th cycle.
- Clean press: gp_raw_i[0] 0->1 held → gp_o[0]=1 after the 3rd mismatching tick (+1 cycle), rise_o=0x01 for exactly 1 cycle. Release → fall_o=0x01 for 1 cycle.
- Bounce: toggle bit 3 high for 5 cycles, low for 3, then high and held → gp_o[3] rises only after 3 consecutive high ticks following the last low sample. Exactly one rise_o pulse.
- Simultaneous events: bits 1 and 6 change together (0x00->0x42) → one cycle with rise_o=0x42, then gp_o=0x42.
- enable_i dropped after 2 mismatching ticks for 20 cycles, then re-asserted with input still changed → gp_o changes only after 3 further ticks.
- Synchronous reset asserted with cnt=2 on bit 2 → gp_o=0x00, no pulse. After release, a new full 3-tick qualification is needed.
